// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core, with load-use hazard
// detection (one bubble, PC and IF/ID frozen) and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W      = 16,
    parameter int REG_ADDR_W  = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [1:0]             id_alu_op,
    input  logic [3:0]             id_func,
    input  logic                   id_alu_src,
    input  logic                   id_reg_dst,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_mem_write,
    input  logic                   id_mem_to_reg,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic [DATA_W-1:0]      id_rs_data,
    input  logic [DATA_W-1:0]      id_rt_data,
    input  logic [DATA_W-1:0]      id_imm,
    input  logic                   flush,
    input  logic                   ex_stall,
    output logic                   ex_valid,
    output logic [1:0]             ex_alu_op,
    output logic [3:0]             ex_func,
    output logic                   ex_alu_src,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_mem_to_reg,
    output logic [REG_ADDR_W-1:0]  ex_rs,
    output logic [REG_ADDR_W-1:0]  ex_rt,
    output logic [REG_ADDR_W-1:0]  ex_dest,
    output logic [DATA_W-1:0]      ex_rs_data,
    output logic [DATA_W-1:0]      ex_rt_data,
    output logic [DATA_W-1:0]      ex_imm,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [1:0]            aluOp;
        logic [3:0]            func;
        logic                  aluSrc;
        logic                  regWrite;
        logic                  memRead;
        logic                  memWrite;
        logic                  memToReg;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     rsData;
        logic [DATA_W-1:0]     rtData;
        logic [DATA_W-1:0]     imm;
    } exBundleT;

    exBundleT               exReg;
    exBundleT               capture;
    logic [STALL_CNT_W-1:0] stallCnt;
    logic                   hazard;

    always_comb begin
        capture          = '0;
        capture.valid    = id_valid;
        capture.aluOp    = id_alu_op;
        capture.func     = id_func;
        capture.aluSrc   = id_alu_src;
        capture.regWrite = id_reg_write;
        capture.memRead  = id_mem_read;
        capture.memWrite = id_mem_write;
        capture.memToReg = id_mem_to_reg;
        capture.rs       = id_rs;
        capture.rt       = id_rt;
        capture.dest     = id_reg_dst ? id_rd : id_rt;
        capture.rsData   = id_rs_data;
        capture.rtData   = id_rt_data;
        capture.imm      = id_imm;
    end

    // A load in EX whose destination feeds the decode slot; register 0 is hardwired so never hazards.
    assign hazard = exReg.valid & exReg.memRead & id_valid & (exReg.dest != '0) &
                    ((exReg.dest == id_rs) | (exReg.dest == id_rt));

    // ex_stall is the downstream not-ready: while it is high nothing moves here or upstream.
    assign pc_write    = ~(hazard | ex_stall);
    assign if_id_write = ~(hazard | ex_stall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exReg    <= '0;
            stallCnt <= '0;
        end else if (flush) begin
            exReg <= '0;
        end else if (!ex_stall) begin
            if (hazard) begin
                exReg <= '0;
                if (stallCnt != '1) stallCnt <= stallCnt + STALL_CNT_W'(1);
            end else begin
                exReg <= capture;
            end
        end
    end

    assign ex_valid      = exReg.valid;
    assign ex_alu_op     = exReg.aluOp;
    assign ex_func       = exReg.func;
    assign ex_alu_src    = exReg.aluSrc;
    assign ex_reg_write  = exReg.regWrite;
    assign ex_mem_read   = exReg.memRead;
    assign ex_mem_write  = exReg.memWrite;
    assign ex_mem_to_reg = exReg.memToReg;
    assign ex_rs         = exReg.rs;
    assign ex_rt         = exReg.rt;
    assign ex_dest       = exReg.dest;
    assign ex_rs_data    = exReg.rsData;
    assign ex_rt_data    = exReg.rtData;
    assign ex_imm        = exReg.imm;
    assign stall_count   = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written load-use/saturation
// sequences and a randomized run against an abstract reference model.
module tb_id_ex_stage;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rstN, flush, stall, idValid;
        logic [1:0]    aluOp;
        logic [3:0]    func;
        logic          aluSrc, regDst, regWrite, memRead, memWrite, memToReg;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] rsData, rtData, imm;
    } in_t;

    typedef struct packed {
        logic          valid;
        logic [1:0]    aluOp;
        logic [3:0]    func;
        logic          aluSrc, regWrite, memRead, memWrite, memToReg;
        logic [AW-1:0] rs, rt, dest;
        logic [DW-1:0] rsData, rtData, imm;
    } ex_t;

    typedef struct {
        in_t        in;
        logic       ePcw;
        logic       eValid;
        logic [3:0] eFunc;
        logic [2:0] eDest;
        logic       eMemRead;
        int         eCnt;
    } vec_t;

    in_t cur;

    logic          ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [1:0]    ex_alu_op;
    logic [3:0]    ex_func;
    logic [AW-1:0] ex_rs, ex_rt, ex_dest;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic          pc_write, if_id_write;
    logic [CW-1:0] stall_count;

    logic          sValid, sAluSrc, sRegWrite, sMemRead, sMemWrite, sMemToReg;
    logic [1:0]    sAluOp;
    logic [3:0]    sFunc;
    logic [AW-1:0] sRs, sRt, sDest;
    logic [DW-1:0] sRsData, sRtData, sImm;
    logic          sPcw, sIfId;
    logic [1:0]    sCount;

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(cur.rstN), .id_valid(cur.idValid), .id_alu_op(cur.aluOp),
        .id_func(cur.func), .id_alu_src(cur.aluSrc), .id_reg_dst(cur.regDst),
        .id_reg_write(cur.regWrite), .id_mem_read(cur.memRead), .id_mem_write(cur.memWrite),
        .id_mem_to_reg(cur.memToReg), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_rs_data(cur.rsData), .id_rt_data(cur.rtData), .id_imm(cur.imm),
        .flush(cur.flush), .ex_stall(cur.stall),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_func(ex_func), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .STALL_CNT_W(2)) sat (
        .clk(clk), .rst_n(cur.rstN), .id_valid(cur.idValid), .id_alu_op(cur.aluOp),
        .id_func(cur.func), .id_alu_src(cur.aluSrc), .id_reg_dst(cur.regDst),
        .id_reg_write(cur.regWrite), .id_mem_read(cur.memRead), .id_mem_write(cur.memWrite),
        .id_mem_to_reg(cur.memToReg), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_rs_data(cur.rsData), .id_rt_data(cur.rtData), .id_imm(cur.imm),
        .flush(cur.flush), .ex_stall(cur.stall),
        .ex_valid(sValid), .ex_alu_op(sAluOp), .ex_func(sFunc), .ex_alu_src(sAluSrc),
        .ex_reg_write(sRegWrite), .ex_mem_read(sMemRead), .ex_mem_write(sMemWrite),
        .ex_mem_to_reg(sMemToReg), .ex_rs(sRs), .ex_rt(sRt), .ex_dest(sDest),
        .ex_rs_data(sRsData), .ex_rt_data(sRtData), .ex_imm(sImm),
        .pc_write(sPcw), .if_id_write(sIfId), .stall_count(sCount)
    );

    int   nChecks = 0;
    int   nPass   = 0;
    ex_t  m;
    int   mCnt;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit modelHazard();
        return m.valid && m.memRead && cur.idValid && (m.dest != 0) &&
               (m.dest == cur.rs || m.dest == cur.rt);
    endfunction

    task automatic modelEdge(input bit hz);
        if (!cur.rstN) begin
            m = '0;
            mCnt = 0;
        end else if (cur.flush) begin
            m = '0;
        end else if (cur.stall) begin
            m = m;
        end else if (hz) begin
            m = '0;
            if (mCnt < CMAX) mCnt++;
        end else begin
            m.valid    = cur.idValid;
            m.aluOp    = cur.aluOp;
            m.func     = cur.func;
            m.aluSrc   = cur.aluSrc;
            m.regWrite = cur.regWrite;
            m.memRead  = cur.memRead;
            m.memWrite = cur.memWrite;
            m.memToReg = cur.memToReg;
            m.rs       = cur.rs;
            m.rt       = cur.rt;
            m.dest     = cur.regDst ? cur.rd : cur.rt;
            m.rsData   = cur.rsData;
            m.rtData   = cur.rtData;
            m.imm      = cur.imm;
        end
    endtask

    // Inputs are already on cur; sample the combinational outputs, clock once, compare everything.
    task automatic step(input bit chkComb, output logic pcwSeen);
        bit hz;
        #1;
        hz = modelHazard();
        pcwSeen = pc_write;
        if (chkComb) begin
            chk("pc_write", pc_write, !(hz || cur.stall));
            chk("if_id_write", if_id_write, !(hz || cur.stall));
            chk("sat_pc_write", sPcw, !(hz || cur.stall));
        end
        @(posedge clk);
        modelEdge(hz);
        #1;
        chk("ex_valid", ex_valid, m.valid);
        chk("ex_alu_op", ex_alu_op, m.aluOp);
        chk("ex_func", ex_func, m.func);
        chk("ex_alu_src", ex_alu_src, m.aluSrc);
        chk("ex_reg_write", ex_reg_write, m.regWrite);
        chk("ex_mem_read", ex_mem_read, m.memRead);
        chk("ex_mem_write", ex_mem_write, m.memWrite);
        chk("ex_mem_to_reg", ex_mem_to_reg, m.memToReg);
        chk("ex_rs", ex_rs, m.rs);
        chk("ex_rt", ex_rt, m.rt);
        chk("ex_dest", ex_dest, m.dest);
        chk("ex_rs_data", ex_rs_data, m.rsData);
        chk("ex_rt_data", ex_rt_data, m.rtData);
        chk("ex_imm", ex_imm, m.imm);
        chk("stall_count", stall_count, mCnt);
        chk("sat_count", sCount, (mCnt > 3) ? 3 : mCnt);
        chk("sat_dest", sDest, m.dest);
    endtask

    function automatic vec_t mk(input logic flush, stall, idValid, memRead,
                                input logic [1:0] aluOp, input logic [3:0] func,
                                input logic regDst, input logic [2:0] rs, rt, rd,
                                input logic ePcw, eValid, input logic [3:0] eFunc,
                                input logic [2:0] eDest, input logic eMemRead, input int eCnt);
        vec_t v;
        v.in.rstN     = 1'b1;
        v.in.flush    = flush;
        v.in.stall    = stall;
        v.in.idValid  = idValid;
        v.in.aluOp    = aluOp;
        v.in.func     = func;
        v.in.aluSrc   = !regDst;
        v.in.regDst   = regDst;
        v.in.regWrite = 1'b1;
        v.in.memRead  = memRead;
        v.in.memWrite = 1'b0;
        v.in.memToReg = memRead;
        v.in.rs       = rs;
        v.in.rt       = rt;
        v.in.rd       = rd;
        v.in.rsData   = DW'($urandom);
        v.in.rtData   = DW'($urandom);
        v.in.imm      = DW'($urandom);
        v.ePcw        = ePcw;
        v.eValid      = eValid;
        v.eFunc       = eFunc;
        v.eDest       = eDest;
        v.eMemRead    = eMemRead;
        v.eCnt        = eCnt;
        return v;
    endfunction

    initial begin
        logic pcw;
        m    = '0;
        mCnt = 0;

        // Reset with garbage on the decode side.
        cur = mk(1, 1, 1, 1, 2'b11, 4'hF, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, 0, 0).in;
        cur.rstN = 1'b0;
        @(posedge clk);
        #1;
        step(0, pcw);
        cur.flush = 1'b0;
        cur.stall = 1'b0;
        step(1, pcw);

        //             fl st iv mr aluOp  func  rD rs rt rd  pcw val fn    dst mr cnt
        tbl.push_back(mk(0, 0, 1, 0, 2'b00, 4'h5, 1, 1, 2, 3,  1,  1, 4'h5, 3, 0, 0)); // normal
        tbl.push_back(mk(0, 0, 1, 1, 2'b00, 4'h0, 0, 1, 2, 0,  1,  1, 4'h0, 2, 1, 0)); // load r2
        tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'h2, 1, 2, 4, 5,  0,  0, 4'h0, 0, 0, 1)); // use r2
        tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'h2, 1, 2, 4, 5,  1,  1, 4'h2, 5, 0, 1)); // replay
        tbl.push_back(mk(0, 0, 1, 1, 2'b00, 4'h0, 0, 3, 0, 0,  1,  1, 4'h0, 0, 1, 1)); // load r0
        tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'h4, 1, 0, 0, 6,  1,  1, 4'h4, 6, 0, 1)); // use r0
        tbl.push_back(mk(0, 0, 1, 1, 2'b00, 4'h0, 0, 1, 7, 0,  1,  1, 4'h0, 7, 1, 1)); // load r7
        tbl.push_back(mk(1, 1, 1, 0, 2'b10, 4'h2, 1, 7, 1, 4,  0,  0, 4'h0, 0, 0, 1)); // flush wins
        tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'hA, 1, 1, 2, 4,  1,  1, 4'hA, 4, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 1, 0, 2'b10, 4'h3, 1, 1, 2, 5, 0, 1, 4'hA, 4, 0, 1)); // held
        tbl.push_back(mk(0, 0, 0, 0, 2'b01, 4'h6, 0, 0, 3, 0,  1,  0, 4'h6, 3, 0, 1)); // idle slot
        tbl.push_back(mk(0, 0, 1, 1, 2'b00, 4'h0, 0, 1, 5, 0,  1,  1, 4'h0, 5, 1, 1)); // load r5
        tbl.push_back(mk(0, 1, 1, 0, 2'b10, 4'h7, 1, 5, 0, 6,  0,  1, 4'h0, 5, 1, 1)); // hazard+stall
        tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'h7, 1, 5, 0, 6,  0,  0, 4'h0, 0, 0, 2)); // bubble
        tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'h7, 1, 5, 0, 6,  1,  1, 4'h7, 6, 0, 2)); // replay

        foreach (tbl[i]) begin
            cur = tbl[i].in;
            step(1, pcw);
            chk($sformatf("tbl%0d_pcw", i), pcw, tbl[i].ePcw);
            chk($sformatf("tbl%0d_valid", i), ex_valid, tbl[i].eValid);
            chk($sformatf("tbl%0d_func", i), ex_func, tbl[i].eFunc);
            chk($sformatf("tbl%0d_dest", i), ex_dest, tbl[i].eDest);
            chk($sformatf("tbl%0d_memrd", i), ex_mem_read, tbl[i].eMemRead);
            chk($sformatf("tbl%0d_cnt", i), stall_count, tbl[i].eCnt);
        end

        // Five load-use bubbles: the 2-bit counter must pin at 3.
        for (int k = 0; k < 5; k++) begin
            cur = mk(0, 0, 1, 1, 2'b00, 4'h0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0).in;
            step(1, pcw);
            cur = mk(0, 0, 1, 0, 2'b10, 4'h2, 1, 3, 1, 4, 0, 0, 0, 0, 0, 0).in;
            step(1, pcw);
            step(1, pcw);
        end
        chk("sat_hold", sCount, 2'd3);
        chk("cnt_after_sat", stall_count, 7);

        // Randomized traffic with occasional reset, flush and stall.
        for (int n = 0; n < 400; n++) begin
            cur.rstN     = ($urandom_range(0, 39) != 0);
            cur.flush    = ($urandom_range(0, 9) == 0);
            cur.stall    = ($urandom_range(0, 5) == 0);
            cur.idValid  = ($urandom_range(0, 4) != 0);
            cur.aluOp    = 2'($urandom);
            cur.func     = 4'($urandom);
            cur.aluSrc   = 1'($urandom);
            cur.regDst   = 1'($urandom);
            cur.regWrite = 1'($urandom);
            cur.memRead  = ($urandom_range(0, 2) == 0);
            cur.memWrite = 1'($urandom);
            cur.memToReg = 1'($urandom);
            cur.rs       = AW'($urandom_range(0, 7));
            cur.rt       = AW'($urandom_range(0, 7));
            cur.rd       = AW'($urandom_range(0, 7));
            cur.rsData   = DW'($urandom);
            cur.rtData   = DW'($urandom);
            cur.imm      = DW'($urandom);
            step(1, pcw);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the pipelined MIPS core; captures decoded control (incl. 2-bit ALU op and 4-bit function field) and operands from decode and presents them to the execute stage.
- ex_alu_op/ex_func drive the ALU control decoder directly.
- Contains load-use hazard detection: inserts one bubble and freezes PC and IF/ID.
- Honours branch flush from later stages and a downstream hold; keeps a saturating load-use stall counter.

Parameters:
DATA_W, 16, operand/immediate width
REG_ADDR_W, 3, register-specifier width
STALL_CNT_W, 16, width of load-use stall counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
id_valid  input  1  decode slot holds a real instruction
id_alu_op  input  2  ALU op class from main control
id_func  input  4  instruction function field
id_alu_src  input  1  1 = immediate as ALU operand B
id_reg_dst  input  1  1 = dest is rd, 0 = rt
id_reg_write  input  1  writes register file
id_mem_read  input  1  load
id_mem_write  input  1  store
id_mem_to_reg  input  1  writeback from memory
id_rs, id_rt, id_rd  input  REG_ADDR_W each  register specifiers
id_rs_data, id_rt_data, id_imm  input  DATA_W each  operands, sign-extended immediate
flush  input  1  branch/jump resolved taken, kill decode slot
ex_stall  input  1  execute cannot accept, hold stage
ex_valid  output  1  execute slot holds real instruction
ex_alu_op  output  2  registered id_alu_op
ex_func  output  4  registered id_func
ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control
ex_rs, ex_rt  output  REG_ADDR_W each  registered sources (for forwarding)
ex_dest  output  REG_ADDR_W  id_reg_dst ? id_rd : id_rt, resolved at capture
ex_rs_data, ex_rt_data, ex_imm  output  DATA_W each  registered operands
pc_write  output  1  PC may advance (combinational)
if_id_write  output  1  IF/ID may load (combinational)
stall_count  output  STALL_CNT_W  load-use bubbles inserted, saturating

Behaviour:
- All state updates on rising clk. rst_n low at an edge: every registered output = 0 (ex_valid=0, ex_alu_op=2'b00, ex_func=4'b0000, all control/specifiers/data = 0, stall_count=0). Reset mid-operation discards the in-flight instruction.
- Hazard (combinational): hazard = ex_valid & ex_mem_read & id_valid & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)). Register 0 never hazards.
- pc_write = if_id_write = ~(hazard | ex_stall) & ~flush_hold_free, where flush_hold_free = 0; i.e. both are low exactly when hazard or ex_stall is high. flush does not affect them; upstream flush is handled elsewhere.
- Per-edge action, highest priority first:
  - rst_n=0: reset.
  - flush=1: load bubble. This overrides ex_stall and hazard.
  - ex_stall=1: hold all registers unchanged.
  - hazard=1: load bubble; stall_count += 1, saturating at all-ones.
  - otherwise: capture all id_* fields; ex_valid = id_valid.
- Bubble: ex_valid=0; all control outputs 0; ex_alu_op=2'b00, ex_func=4'b0000; specifiers and data 0.
- Latency: 1 cycle from id_* to ex_*.
- Load-use costs exactly one bubble: after the bubble, ex_mem_read=0, so hazard clears and the held decode instruction is captured next cycle.
- id_valid=0 with no hazard: capture proceeds, ex_valid=0. Control fields pass through unchanged; consumers must gate them with ex_valid.
- stall_count increments only on hazard edges that are not overridden by flush or ex_stall.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random id_* -> all ex_* = 0, stall_count=0; pc_write=if_id_write=1 after release.
- Normal flow: id_alu_op=2'b00, id_func=4'b0101, rs=1, rt=2, rd=3, reg_dst=1 -> next cycle ex_alu_op=00, ex_func=0101, ex_dest=3, ex_valid=1.
- Load-use: load with dest 2 in EX (ex_mem_read=1), decode add using rs=2 -> pc_write=if_id_write=0 that cycle; next edge loads bubble (ex_valid=0, ex_func=0); following edge captures the add; stall_count=1.
- Reg-0 / no-hazard: load with ex_dest=0 and id_rs=0 -> no stall, stall_count unchanged.
- Priority: flush=1 together with hazard=1 and ex_stall=1 -> bubble loaded, stall_count unchanged; ex_stall=1 alone for 3 cycles -> ex_* frozen, pc_write=0.
- Saturation: STALL_CNT_W=2, trigger 5 load-use bubbles -> stall_count stays at 3.
